// File: rtl/timer_display.sv
// timer_display: scans the timer's BCD time onto an 8-digit common-anode
// seven-segment display (HH.MM.SS.cc), blinking the digit under edit and
// flashing the whole display once the timer has expired.
module timer_display #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] bcd_i,
  input  logic [2:0]  curr_digit,
  input  logic        edit,
  input  logic        done,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [31:0]        snap_q, snap_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic               edit_q, done_q;
  logic               tick, restart;
  logic [3:0]         nib;
  logic [7:0]         an_d;
  logic [6:0]         seg_d;
  logic               dp_d;
  logic               edit_blank, done_blank;

  // Scan divider, digit index and per-frame snapshot of the time value
  always_comb begin
    tick       = (scan_cnt_q == SCAN_MAX);
    scan_cnt_d = tick ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d      = tick ? idx_q - 3'd1 : idx_q;
    snap_d     = (tick && idx_q == 3'd0) ? bcd_i[35:4] : snap_q;
  end

  // Blink half-period counter; restarts in the visible half on edit/done rise
  always_comb begin
    restart       = (edit && !edit_q) || (done && !done_q);
    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;
    if (restart) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Digit decode, decimal point and blanking for the slot selected by idx
  always_comb begin
    nib = snap_q[{idx_q, 2'b00} +: 4];
    unique case (nib)
      4'd0:    seg_d = 7'h40;
      4'd1:    seg_d = 7'h79;
      4'd2:    seg_d = 7'h24;
      4'd3:    seg_d = 7'h30;
      4'd4:    seg_d = 7'h19;
      4'd5:    seg_d = 7'h12;
      4'd6:    seg_d = 7'h02;
      4'd7:    seg_d = 7'h78;
      4'd8:    seg_d = 7'h00;
      4'd9:    seg_d = 7'h10;
      default: seg_d = 7'h3F;
    endcase
    edit_blank = edit && (curr_digit <= 3'd5) && blink_phase_q &&
                 (idx_q == 3'd7 - curr_digit);
    done_blank = done && !edit && blink_phase_q;
    an_d = ~(8'b1 << idx_q);
    dp_d = !(idx_q == 3'd6 || idx_q == 3'd4 || idx_q == 3'd2);
    if (edit_blank || done_blank) begin
      an_d = '1;
      dp_d = 1'b1;
    end
  end

  // State and registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q    <= '0;
      idx_q         <= 3'd7;
      snap_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      edit_q        <= 1'b0;
      done_q        <= 1'b0;
      an            <= '1;
      seg           <= '1;
      dp            <= 1'b1;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      edit_q        <= edit;
      done_q        <= done;
      an            <= an_d;
      seg           <= seg_d;
      dp            <= dp_d;
    end
  end

endmodule

// File: doc/timer_display.md
Name: timer_display

Overview:
- Display-side consumer of the countdown timer's 36-bit BCD time, current-digit, edit and done outputs.
- Time-multiplexes eight digits, HH.MM.SS.cc (h2 h1 m2 m1 s2 s1 ms3 ms2), onto the board's 8-digit common-anode seven-segment display. ms1 is not shown.
- Blinks the digit under edit while in edit mode, and flashes the whole display when the timer has expired.
- Sits between the timer and the top-level board pins.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot. Scan-step period, ~1 kHz at 100 MHz.
- BLINK_DIV, 25000000: clk cycles per blink half-period. 2 Hz blink at 100 MHz.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- bcd_i  in  36  BCD time, nibbles [35:32]=h2 ... [3:0]=ms1
- curr_digit  in  3  digit under edit; 0=h2, 1=h1, 2=m2, 3=m1, 4=s2, 5=s1
- edit  in  1  timer in edit mode
- done  in  1  timer expired
- an  out  8  anode enables, active-low; an[7]=leftmost (h2), an[0]=ms2
- seg  out  7  cathodes, active-low; seg[6:0]=g,f,e,d,c,b,a
- dp  out  1  decimal point, active-low

Behaviour:
- All of an, seg and dp are registered. Reset values: an=8'hFF, seg=7'h7F, dp=1 (display dark).
- Internal reset values: scan_cnt=0, idx=7, snap=0, blink_cnt=0, blink_phase=0, edit_q=0, done_q=0.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted in the cycle scan_cnt==SCAN_DIV-1.
  - On tick, idx decrements 7→6→...→0→7.
- Frame snapshot:
  - On the tick where idx==0 (wrap to 7), snap <= bcd_i[35:4].
  - Within a frame, all digits come from snap, so there is no tearing mid-frame.
  - The first frame after reset displays all zeros.
- Output register: updated every cycle from the current idx, snap, blink_phase, edit, done and curr_digit. The visible response to an idx change is therefore 1 cycle after tick.
- Digit selection: position p=idx, nibble = snap[4p+3:4p]; p=7 is h2, p=0 is ms2.
- Decode (seg, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Nibble values 10..15 decode to 3F ('-', g only).
- Decimal point: dp=0 when p is 6, 4 or 2 (after h1, m1, s1) and the digit is visible; otherwise dp=1.
- Normal display: an = ~(8'b1 << idx).
- Blink counter:
  - blink_cnt counts 0..BLINK_DIV-1.
  - At terminal count it wraps and toggles blink_phase.
  - blink_phase=1 means the blanked half.
- Blink restart: edit_q and done_q register edit and done. On a rising edge of edit or of done, blink_cnt <= 0 and blink_phase <= 0, so blinking always starts in the visible half.
- Edit blanking:
  - Condition: edit=1, curr_digit<=5, blink_phase=1 and idx==7-curr_digit.
  - When met: an=8'hFF and dp=1 for that slot. The other digits display normally.
  - curr_digit 6 or 7 means no digit is blanked.
- Done flash: when done=1, edit=0 and blink_phase=1, an=8'hFF for every slot. Edit takes priority over done.
- When edit=0 and done=0, blink_phase has no visible effect; the counter keeps running.
- Asserting rst mid-frame forces all outputs to reset values immediately. Scanning restarts at idx=7 after release.
- One slot is enabled at any time; there is never more than one an bit low.

Test Plan:
- SCAN_DIV=4, BLINK_DIV=16; reset, bcd_i=36'h123456789, edit=0, done=0; run 2 frames.
  - Frame 1: every slot shows seg=40.
  - Frame 2: an cycles FE..7F pattern from 7F down; slot7 seg=79 ("1"), slot6 seg=24 with dp=0, slot0 seg=00 ("8").
- Change bcd_i mid-frame.
  - Remaining slots of the current frame keep the old digits.
  - The new value appears only after the next idx 0→7 wrap.
- bcd_i=36'hFA0000000.
  - Slots 7 and 6 show seg=3F.
  - No slot ever has more than one an bit low.
- edit rises with curr_digit=3.
  - blink_cnt restarts; slot 4 is visible for 16 cycles, then blanked (an=FF, dp=1) for 16 cycles.
  - Other slots are unaffected.
  - curr_digit=6: no blanking.
- done=1, edit=0: all slots dark for 16 cycles, visible for 16 cycles, repeating. Raising edit while done=1 switches to single-digit blinking.
- Assert rst mid-scan: an=FF, seg=7F, dp=1 in the same cycle (asynchronous). After release, the first enabled slot is idx 7.
